// File: rtl/overflow_acc_monitor.sv
// rtl/overflow_acc_monitor.sv - streaming add/sub accumulator with overflow detect, clamp and event count
// Flags always describe the operation just accepted; signed_mode only selects which flag drives clamp/count.

module overflow_acc_monitor #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [N-1:0]  din,
  input  logic          sub,
  input  logic          signed_mode,
  input  logic          sat_en,
  output logic [N-1:0]  acc,
  output logic          out_valid,
  output logic          ovf_u,
  output logic          ovf_s,
  output logic          sticky_u,
  output logic          sticky_s,
  output logic [CW-1:0] ovf_count
);

  logic [N-1:0]  r_acc;
  logic          r_out_valid;
  logic          r_ovf_u;
  logic          r_ovf_s;
  logic          r_sticky_u;
  logic          r_sticky_s;
  logic [CW-1:0] r_ovf_count;

  logic [N:0]    w_raw;
  logic [N-1:0]  w_wrap;
  logic          w_ovf_u;
  logic          w_ovf_s;
  logic          w_act;
  logic [N-1:0]  w_sat_val;
  logic [N-1:0]  w_next_acc;
  logic          w_cnt_full;

  // In N+1 bits the top bit is the carry on add and the borrow on sub.
  assign w_raw  = sub ? ({1'b0, r_acc} - {1'b0, din}) : ({1'b0, r_acc} + {1'b0, din});
  assign w_wrap = w_raw[N-1:0];

  assign w_ovf_u = w_raw[N];
  assign w_ovf_s = sub ? ((r_acc[N-1] != din[N-1]) && (w_wrap[N-1] != r_acc[N-1]))
                       : ((r_acc[N-1] == din[N-1]) && (w_wrap[N-1] != r_acc[N-1]));

  assign w_act = signed_mode ? w_ovf_s : w_ovf_u;

  always_comb begin
    w_sat_val = '0;
    if (signed_mode) begin
      w_sat_val = r_acc[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      w_sat_val = sub ? {N{1'b0}} : {N{1'b1}};
    end
  end

  assign w_next_acc = (sat_en && w_act) ? w_sat_val : w_wrap;
  assign w_cnt_full = (r_ovf_count == {CW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_ovf_u     <= 1'b0;
      r_ovf_s     <= 1'b0;
      r_sticky_u  <= 1'b0;
      r_sticky_s  <= 1'b0;
      r_ovf_count <= '0;
    end else if (in_valid) begin
      r_acc       <= w_next_acc;
      r_out_valid <= 1'b1;
      r_ovf_u     <= w_ovf_u;
      r_ovf_s     <= w_ovf_s;
      r_sticky_u  <= r_sticky_u | w_ovf_u;
      r_sticky_s  <= r_sticky_s | w_ovf_s;
      if (w_act && !w_cnt_full) begin
        r_ovf_count <= r_ovf_count + CW'(1);
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign acc       = r_acc;
  assign out_valid = r_out_valid;
  assign ovf_u     = r_ovf_u;
  assign ovf_s     = r_ovf_s;
  assign sticky_u  = r_sticky_u;
  assign sticky_s  = r_sticky_s;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_overflow_acc_monitor.sv
// tb/tb_overflow_acc_monitor.sv - randomized bench with an integer-arithmetic reference model
// Two instances (CW=4 and CW=2) share stimulus so the counter saturation point is exercised.

module tb_overflow_acc_monitor;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sub = 1'b0;
  logic       signed_mode = 1'b0;
  logic       sat_en = 1'b0;

  logic [7:0] acc, acc2;
  logic       out_valid, ovf_u, ovf_s, sticky_u, sticky_s;
  logic       out_valid2, ovf_u2, ovf_s2, sticky_u2, sticky_s2;
  logic [3:0] ovf_count;
  logic [1:0] ovf_count2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference state
  int m_acc, m_ov, m_u, m_s, m_su, m_ss, m_cnt4, m_cnt2;

  overflow_acc_monitor #(.N(8), .CW(4)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .din(din),
    .sub(sub), .signed_mode(signed_mode), .sat_en(sat_en),
    .acc(acc), .out_valid(out_valid), .ovf_u(ovf_u), .ovf_s(ovf_s),
    .sticky_u(sticky_u), .sticky_s(sticky_s), .ovf_count(ovf_count)
  );

  overflow_acc_monitor #(.N(8), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .din(din),
    .sub(sub), .signed_mode(signed_mode), .sat_en(sat_en),
    .acc(acc2), .out_valid(out_valid2), .ovf_u(ovf_u2), .ovf_s(ovf_s2),
    .sticky_u(sticky_u2), .sticky_s(sticky_s2), .ovf_count(ovf_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Model: exact integer result, then range test and clamp to the interpreted range.
  task automatic model_step(input bit r, input bit c, input bit v, input bit s,
                            input int d, input bit sm, input bit se);
    int ures, sres, nxt;
    bit ou, os, act;
    if (r || c) begin
      m_acc = 0; m_ov = 0; m_u = 0; m_s = 0; m_su = 0; m_ss = 0; m_cnt4 = 0; m_cnt2 = 0;
    end else if (v) begin
      ures = s ? m_acc - d : m_acc + d;
      sres = s ? to_signed(m_acc) - to_signed(d) : to_signed(m_acc) + to_signed(d);
      ou = (ures < 0) || (ures > 255);
      os = (sres < -128) || (sres > 127);
      act = sm ? os : ou;
      if (se && act) begin
        if (sm) nxt = (sres > 127) ? 127 : -128;
        else    nxt = (ures > 255) ? 255 : 0;
      end else begin
        nxt = ures;
      end
      m_acc = ((nxt % 256) + 256) % 256;
      m_ov = 1; m_u = ou; m_s = os;
      m_su = m_su | ou; m_ss = m_ss | os;
      if (act && m_cnt4 < 15) m_cnt4++;
      if (act && m_cnt2 < 3) m_cnt2++;
    end else begin
      m_ov = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input bit s,
                     input int d, input bit sm, input bit se);
    rst = r; clear = c; in_valid = v; sub = s; din = d[7:0];
    signed_mode = sm; sat_en = se;
    @(posedge clk);
    model_step(r, c, v, s, d, sm, se);
    @(negedge clk);
  endtask

  task automatic op(input bit s, input int d, input bit sm, input bit se);
    cyc(1'b0, 1'b0, 1'b1, s, d, sm, se);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("acc", acc, m_acc);
      chk("out_valid", out_valid, m_ov);
      chk("ovf_u", ovf_u, m_u);
      chk("ovf_s", ovf_s, m_s);
      chk("sticky_u", sticky_u, m_su);
      chk("sticky_s", sticky_s, m_ss);
      chk("ovf_count", ovf_count, m_cnt4);
      chk("acc_cw2", acc2, m_acc);
      chk("ovf_count_cw2", ovf_count2, m_cnt2);
    end
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("lit_reset_acc", acc, 0);
    chk("lit_reset_valid", out_valid, 0);
    chk("lit_reset_count", ovf_count, 0);

    // signed wrap to 0x80
    op(1'b0, 8'h7F, 1'b1, 1'b0);
    chk("lit_t1_valid1", out_valid, 1);
    op(1'b0, 8'h01, 1'b1, 1'b0);
    chk("lit_t1_acc", acc, 8'h80);
    chk("lit_t1_ovf_s", ovf_s, 1);
    chk("lit_t1_ovf_u", ovf_u, 0);
    chk("lit_t1_sticky_s", sticky_s, 1);
    chk("lit_t1_count", ovf_count, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("lit_t1_valid_drop", out_valid, 0);

    // signed saturate at +max
    do_reset();
    op(1'b0, 8'h7F, 1'b1, 1'b1);
    op(1'b0, 8'h01, 1'b1, 1'b1);
    chk("lit_t2_acc", acc, 8'h7F);
    chk("lit_t2_count", ovf_count, 1);
    op(1'b0, 8'h01, 1'b1, 1'b1);
    chk("lit_t2_acc2", acc, 8'h7F);
    chk("lit_t2_count2", ovf_count, 2);

    // unsigned carry / borrow
    do_reset();
    op(1'b0, 8'hFF, 1'b0, 1'b0);
    op(1'b0, 8'h01, 1'b0, 1'b0);
    chk("lit_t3_acc_wrap", acc, 8'h00);
    chk("lit_t3_ovf_u", ovf_u, 1);
    chk("lit_t3_ovf_s", ovf_s, 0);
    do_reset();
    op(1'b0, 8'hFF, 1'b0, 1'b0);
    op(1'b0, 8'h01, 1'b0, 1'b1);
    chk("lit_t3_acc_sat", acc, 8'hFF);
    do_reset();
    op(1'b1, 8'h01, 1'b0, 1'b1);
    chk("lit_t3_sub_acc", acc, 8'h00);
    chk("lit_t3_sub_ovf_u", ovf_u, 1);

    // signed saturate at -min, then a clean op
    do_reset();
    op(1'b0, 8'h80, 1'b1, 1'b1);
    op(1'b1, 8'h01, 1'b1, 1'b1);
    chk("lit_t4_acc", acc, 8'h80);
    chk("lit_t4_ovf_s", ovf_s, 1);
    op(1'b0, 8'h05, 1'b1, 1'b1);
    chk("lit_t4_acc2", acc, 8'h85);
    chk("lit_t4_ovf_s2", ovf_s, 0);
    chk("lit_t4_ovf_u2", ovf_u, 0);
    chk("lit_t4_sticky_s", sticky_s, 1);

    // counter saturation on the CW=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) op(1'b1, 8'h01, 1'b0, 1'b1);
    chk("lit_t5_count_cw2", ovf_count2, 3);
    chk("lit_t5_count_cw4", ovf_count, 5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("lit_t5_clr_acc", acc, 0);
    chk("lit_t5_clr_count", ovf_count2, 0);
    chk("lit_t5_clr_sticky", sticky_u, 0);

    // clear/reset collisions with an operand
    do_reset();
    op(1'b0, 8'h33, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    chk("lit_t6_clr_acc", acc, 0);
    chk("lit_t6_clr_valid", out_valid, 0);
    op(1'b0, 8'h10, 1'b0, 1'b0);
    chk("lit_t6_after_clr", acc, 8'h10);
    op(1'b0, 8'hF8, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    chk("lit_t6_rst_acc", acc, 0);
    chk("lit_t6_rst_sticky", sticky_u, 0);
    op(1'b0, 8'h10, 1'b0, 1'b0);
    chk("lit_t6_after_rst", acc, 8'h10);

    // randomized stream, operands biased toward range edges
    for (int i = 0; i < 4000; i++) begin
      int d;
      int pick;
      pick = $urandom_range(0, 7);
      case (pick)
        0: d = 8'h7F;
        1: d = 8'h80;
        2: d = 8'hFF;
        3: d = 8'h01;
        default: d = $urandom_range(0, 255);
      endcase
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, d,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/overflow_acc_monitor.md
Name: overflow_acc_monitor

Overview:
Parametrised N-bit streaming accumulator with per-operation add/subtract, runtime signed/unsigned interpretation, and optional saturation. It detects unsigned carry/borrow and signed overflow on every accepted operand. It keeps sticky flags and a saturating overflow-event counter. It sits after datapath arithmetic stages as a registered range monitor and clamp.

Parameters:
N, 8, operand/accumulator width in bits (N >= 2)
CW, 4, overflow event counter width in bits (CW >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous clear of accumulator, sticky flags and counter
in_valid  input  1  operand din is presented this cycle
din  input  N  operand
sub  input  1  0: acc + din, 1: acc - din (sampled with in_valid)
signed_mode  input  1  1: two's-complement interpretation for saturation/counting (sampled with in_valid)
sat_en  input  1  1: clamp result on active overflow (sampled with in_valid)
acc  output  N  registered accumulator value
out_valid  output  1  one-cycle pulse: acc/flags reflect the operand accepted the previous cycle
ovf_u  output  1  unsigned overflow of last operation (carry on add, borrow on sub)
ovf_s  output  1  signed overflow of last operation
sticky_u  output  1  OR of all ovf_u since reset/clear
sticky_s  output  1  OR of all ovf_s since reset/clear
ovf_count  output  CW  count of active overflows (selected by signed_mode), saturating

Behaviour:
- Reset: the block has one clock and uses a synchronous, active-high reset. rst high at a clk edge sets acc=0, out_valid=0, ovf_u=0, ovf_s=0, sticky_u=0, sticky_s=0, ovf_count=0.
- rst has priority over clear, and clear has priority over in_valid.
- Reset or clear asserted mid-stream discards that cycle's operand. The next valid operand operates on acc=0.
- clear (rst low): acc, flags, sticky flags and counter go to 0; out_valid=0 next cycle.
- Accept: in_valid=1 with rst=0 and clear=0. There is no backpressure; every operand is accepted.
- Latency: 1 cycle. Results are registered at the edge where the operand is accepted, and out_valid=1 for exactly one cycle.
- When in_valid=0: acc, ovf_u, ovf_s, sticky flags and counter hold; out_valid=0.
- Raw result: compute in N+1 bits. Add: r = {0,acc} + {0,din}. Sub: r = {0,acc} - {0,din}. wrap = r[N-1:0].
- ovf_u: add -> r[N]; sub -> borrow (acc < din unsigned).
- ovf_s, add: acc[N-1]==din[N-1] and wrap[N-1]!=acc[N-1].
- ovf_s, sub: acc[N-1]!=din[N-1] and wrap[N-1]!=acc[N-1].
- Both flags are always computed, independent of signed_mode.
- Active overflow: act = signed_mode ? ovf_s : ovf_u.
- Next acc when sat_en=0 or act=0: wrap.
- Next acc when sat_en=1 and act=1, signed mode: acc[N-1]==0 -> 0111..1; acc[N-1]==1 -> 1000..0.
- Next acc when sat_en=1 and act=1, unsigned mode: add -> all ones; sub -> 0.
- sticky_u |= ovf_u and sticky_s |= ovf_s on each accepted operand.
- ovf_count increments by 1 on each accepted operand with act=1. It holds at 2^CW-1 and never wraps.
- No overflow on an accepted operand clears ovf_u/ovf_s for that result; sticky flags do not clear.
- Mode inputs may change every operand. Flags always describe the operation just performed.

Test Plan:
1. N=8, reset, then add 0x7F, then add 0x01 with signed_mode=1, sat_en=0 -> after second op: acc=0x80, ovf_s=1, ovf_u=0, sticky_s=1, ovf_count=1, out_valid pulsed once per op.
2. Repeat scenario 1 with sat_en=1 -> acc=0x7F, ovf_s=1, count=1. Then add 0x01 again -> acc=0x7F, count=2.
3. Unsigned, signed_mode=0: acc=0xFF, add 0x01, sat_en=0 -> acc=0x00, ovf_u=1, ovf_s=0. With sat_en=1 -> acc=0xFF. Sub 0x01 from 0x00 with sat_en=1 -> acc=0x00, ovf_u=1.
4. Signed sub: acc=0x80, sub 0x01, signed_mode=1, sat_en=1 -> acc=0x80, ovf_s=1. Next op acc=0x80 add 0x05 -> acc=0x85, ovf_s=0, ovf_u=0, sticky_s stays 1.
5. CW=2: five consecutive active overflows -> ovf_count reaches 3 and holds. Then clear -> acc=0, count=0, sticky flags=0.
6. Simultaneous events: clear and in_valid together -> acc=0, out_valid=0. rst and clear together during a stream -> all outputs 0. The first operand after either (add 0x10) -> acc=0x10.
